// File: rtl/wave_scale_ctrl.sv
// wave_scale_ctrl: captures one frame of signed samples, scales them through
// an external 10x10 multiplier and writes clamped screen rows to a line RAM.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   arm, gain                start request (IDLE only), Q3.6 gain latched on arm
//   sample_valid/ready/sample upstream sample handshake
//   mul_a, mul_b, mul_p      multiplier operands and combinational product
//   wr_en, wr_addr, wr_data  line-RAM write port
//   busy, done               frame in progress, end-of-frame pulse
module wave_scale_ctrl #(
  parameter int COLS     = 640,
  parameter int ROWS     = 480,
  parameter int SHIFT    = 6,
  parameter int Y_CENTER = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic [9:0]  gain,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [9:0]  sample,
  output logic [9:0]  mul_a,
  output logic [9:0]  mul_b,
  input  logic [19:0] mul_p,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [8:0]  wr_data,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [9:0] LAST = 10'(COLS - 1);
  localparam logic signed [20:0] RND =
    21'sd1 <<< (SHIFT - 1);
  localparam logic signed [20:0] YC   = 21'(Y_CENTER);
  localparam logic signed [20:0] YMAX = 21'(ROWS - 1);
  localparam logic [8:0] RMAX = 9'(ROWS - 1);

  logic [1:0]  state;
  logic        v0;
  logic        v1;
  logic [19:0] prod;
  logic [9:0]  col;
  logic [9:0]  acc;
  logic        xfer;

  logic signed [20:0] sum;
  logic signed [20:0] r;
  logic signed [20:0] y;
  logic [8:0]         row;

  assign sample_ready = (state == CAPTURE);
  assign busy = (state == CAPTURE) || (state == FLUSH);
  assign done = (state == DONE);
  assign xfer = sample_valid && sample_ready;

  // Round half up, then map sample 0 to Y_CENTER
  // (positive values go up the screen).
  always_comb begin
    sum = $signed({prod[19], prod}) + RND;
    r   = sum >>> SHIFT;
    y   = YC - r;
    row = y[8:0];
    if (y < 0) begin
      row = '0;
    end else if (y > YMAX) begin
      row = RMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      v0      <= 1'b0;
      v1      <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      prod    <= '0;
      col     <= '0;
      acc     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      v0 <= xfer;
      if (xfer) begin
        mul_a <= sample;
      end
      prod    <= mul_p;
      v1      <= v0;
      wr_en   <= v1;
      wr_data <= row;
      wr_addr <= col;
      if (v1) begin
        col <= (col == LAST) ? '0 : col + 10'd1;
      end

      unique case (state)
        IDLE: begin
          if (arm) begin
            mul_b <= gain;
            col   <= '0;
            acc   <= '0;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (xfer) begin
            acc <= acc + 10'd1;
            if (acc == LAST) begin
              state <= FLUSH;
            end
          end
        end
        // v0/v1 empty means the last write is in
        // the output register this cycle.
        FLUSH: begin
          if (!v0 && !v1) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_scale_ctrl.sv
// tb_wave_scale_ctrl: directed frames through wave_scale_ctrl with a
// behavioural multiplier; write log collected on the falling edge.
module tb_wave_scale_ctrl;

  localparam int COLS = 640;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic [9:0]  gain;
  logic        sample_valid;
  logic        sample_ready;
  logic [9:0]  sample;
  logic [9:0]  mul_a;
  logic [9:0]  mul_b;
  logic [19:0] mul_p;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [8:0]  wr_data;
  logic        busy;
  logic        done;

  logic signed [19:0] ea;
  logic signed [19:0] eb;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int q_addr[$];
  int q_data[$];
  int q_cyc[$];
  int acc_cyc[$];
  int done_cyc[$];
  int done_busy[$];
  int svec[$];
  int exp_data[$];

  wave_scale_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .gain         (gain),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample       (sample),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_p        (mul_p),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  assign ea = {{10{mul_a[9]}}, mul_a};
  assign eb = {{10{mul_b[9]}}, mul_b};
  assign mul_p = ea * eb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(int'(wr_addr));
      q_data.push_back(int'(wr_data));
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(int'(busy));
    end
  end

  function automatic int model(int s, int g);
    real p;
    int  r;
    int  y;
    p = real'(s * g);
    r = int'($floor(p / 64.0 + 0.5));
    y = 240 - r;
    if (y < 0) return 0;
    if (y > 479) return 479;
    return y;
  endfunction

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    acc_cyc.delete();
    done_cyc.delete();
    done_busy.delete();
  endtask

  // Arms with gain g, streams svec at pct% valid, optionally pulses
  // arm with gain=10 at sample chg_at, and checks the full frame.
  task automatic run_frame(input int g, input int pct,
                           input int chg_at, input bit partial);
    int i;
    int guard;
    int bad;
    bit chg_done;
    @(negedge clk);
    arm  = 1'b1;
    gain = 10'(g);
    @(negedge clk);
    arm = 1'b0;
    checks++;
    if ({busy, sample_ready} !== 2'b11 || mul_b !== 10'(g)) begin
      errors++;
      $display("FAIL arm: busy=%b ready=%b mul_b=%0d want 1 1 %0d",
               busy, sample_ready, mul_b, g);
    end
    clear_q();
    i = 0;
    guard = 0;
    chg_done = 1'b0;
    while (i < svec.size() && guard < 4 * COLS) begin
      arm = 1'b0;
      if (chg_at >= 0 && i == chg_at && !chg_done) begin
        arm = 1'b1;
        gain = 10'd10;
        chg_done = 1'b1;
      end
      sample = 10'(svec[i]);
      sample_valid = (int'($urandom_range(99)) < pct);
      if (sample_valid && sample_ready) begin
        acc_cyc.push_back(cyc + 1);
        i++;
      end
      @(negedge clk);
      guard++;
    end
    sample_valid = 1'b0;
    arm = 1'b0;
    checks++;
    if (i != svec.size()) begin
      errors++;
      $display("FAIL feed_timeout: accepted=%0d want %0d", i, svec.size());
    end
    if (!partial) begin
      checks++;
      if (sample_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL ready_drop: ready=%b busy=%b want 0 1",
                 sample_ready, busy);
      end
      for (int k = 0; k < 20 && done_cyc.size() == 0; k++)
        @(negedge clk);
      repeat (3) @(negedge clk);

      checks++;
      if (q_addr.size() != COLS) begin
        errors++;
        $display("FAIL wr_count: got=%0d want %0d", q_addr.size(), COLS);
      end
      bad = 0;
      foreach (q_addr[k]) if (q_addr[k] != k) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL addr_seq: bad_addrs=%0d want 0", bad);
      end
      bad = 0;
      foreach (q_data[k])
        if (k >= exp_data.size() || q_data[k] != exp_data[k]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL wr_data: bad_rows=%0d want 0", bad);
      end
      bad = 0;
      foreach (q_cyc[k])
        if (k >= acc_cyc.size() || q_cyc[k] != acc_cyc[k] + 2) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL latency: bad_writes=%0d want 0", bad);
      end
      checks++;
      if (done_cyc.size() != 1 || q_cyc.size() == 0 ||
          done_cyc[0] != q_cyc[q_cyc.size() - 1] + 1 ||
          done_busy[0] != 0) begin
        errors++;
        $display("FAIL done_pulse: pulses=%0d want 1 one cycle after last write, busy low",
                 done_cyc.size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arm = 1'b0;
    gain = '0;
    sample_valid = 1'b0;
    sample = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sample_ready, mul_a, mul_b, wr_en, wr_addr,
         wr_data, busy, done} !== 43'd0) begin
      errors++;
      $display("FAIL reset: ready=%b a=%0d b=%0d en=%b addr=%0d data=%0d busy=%b done=%b want all 0",
               sample_ready, mul_a, mul_b, wr_en, wr_addr,
               wr_data, busy, done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sample_ready !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL idle: busy=%b ready=%b en=%b want 0 0 0",
               busy, sample_ready, wr_en);
    end
  endtask

  task automatic test_full_frame();
    svec.delete();
    exp_data.delete();
    for (int k = 0; k < COLS; k++) begin
      svec.push_back(100);
      exp_data.push_back(140);
    end
    run_frame(64, 100, -1, 1'b0);
    checks++;
    if (acc_cyc.size() != COLS ||
        acc_cyc[COLS - 1] - acc_cyc[0] != COLS - 1) begin
      errors++;
      $display("FAIL throughput: accepts=%0d want %0d back to back",
               acc_cyc.size(), COLS);
    end
    checks++;
    if (q_data.size() == 0 || q_data[0] != 140) begin
      errors++;
      $display("FAIL row_140: got=%0d want 140",
               q_data.size() ? q_data[0] : -1);
    end
  endtask

  task automatic test_clamp();
    svec.delete();
    exp_data.delete();
    svec = '{-300, 300, -239, 240};
    exp_data = '{479, 0, 479, 0};
    for (int k = 4; k < COLS; k++) begin
      svec.push_back(0);
      exp_data.push_back(240);
    end
    run_frame(64, 100, -1, 1'b0);
    checks++;
    if (q_data.size() < 2 || q_data[0] != 479 || q_data[1] != 0) begin
      errors++;
      $display("FAIL clamp: got=%0d,%0d want 479,0",
               q_data.size() > 0 ? q_data[0] : -1,
               q_data.size() > 1 ? q_data[1] : -1);
    end
  endtask

  task automatic test_round();
    svec.delete();
    exp_data.delete();
    svec = '{1, -1, -3};
    exp_data = '{239, 240, 241};
    for (int k = 3; k < COLS; k++) begin
      svec.push_back(0);
      exp_data.push_back(240);
    end
    run_frame(32, 100, -1, 1'b0);
    checks++;
    if (q_data.size() < 3 || q_data[0] != 239 ||
        q_data[1] != 240 || q_data[2] != 241) begin
      errors++;
      $display("FAIL round: got=%0d,%0d,%0d want 239,240,241",
               q_data.size() > 0 ? q_data[0] : -1,
               q_data.size() > 1 ? q_data[1] : -1,
               q_data.size() > 2 ? q_data[2] : -1);
    end
  endtask

  task automatic test_gap_gain();
    int s;
    svec.delete();
    exp_data.delete();
    for (int k = 0; k < COLS; k++) begin
      s = int'($urandom_range(600)) - 300;
      svec.push_back(s);
      exp_data.push_back(model(s, 64));
    end
    run_frame(64, 50, 200, 1'b0);
    checks++;
    if (mul_b !== 10'd64) begin
      errors++;
      $display("FAIL armed_gain: mul_b=%0d want 64", mul_b);
    end
  endtask

  task automatic test_reset_mid();
    svec.delete();
    exp_data.delete();
    for (int k = 0; k < 100; k++) svec.push_back(100);
    run_frame(64, 100, -1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({sample_ready, mul_a, mul_b, wr_en, wr_addr,
         wr_data, busy, done} !== 43'd0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b a=%0d b=%0d en=%b addr=%0d data=%0d busy=%b done=%b want all 0",
               sample_ready, mul_a, mul_b, wr_en, wr_addr,
               wr_data, busy, done);
    end
    rst_n = 1'b1;
    clear_q();
    repeat (10) @(negedge clk);
    checks++;
    if (q_addr.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: writes=%0d dones=%0d busy=%b want 0 0 0",
               q_addr.size(), done_cyc.size(), busy);
    end
    svec.delete();
    for (int k = 0; k < COLS; k++) begin
      svec.push_back(50);
      exp_data.push_back(190);
    end
    run_frame(64, 100, -1, 1'b0);
    checks++;
    if (q_addr.size() == 0 || q_addr[0] != 0 || q_data[0] != 190) begin
      errors++;
      $display("FAIL restart: addr=%0d data=%0d want 0 190",
               q_addr.size() ? q_addr[0] : -1,
               q_data.size() ? q_data[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_clamp();
    test_round();
    test_gap_gain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
